uart_fifo_io: RTL and testbench

Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a programmable baud divisor, sticky error flags and a level interrupt. It sits on the CPU I/O bus next to the GPIO/SPI registers and decodes a block of `NREG` word addresses starting at `BASE`. Unlike the unbuffered UART path, it never loses back-to-back CPU writes or received bytes until a FIFO is genuinely full, and it runs entirely on the CPU clock.

---
 rtl/uart_fifo_pkg.sv | 48 ++++
 rtl/uart_fifo_io_if.sv | 17 +
 rtl/uart_fifo_io_sync_fifo.sv | 66 ++++++
 rtl/uart_fifo_io.sv | 266 ++++++++++++++++++++++++++
 tb/tb_uart_fifo_io.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_pkg
// Description : Register map, STATUS bit indices, FSM state encodings and the
//               divisor clamp shared by the buffered UART peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_fifo_pkg;

    localparam logic [2:0] c_off_data   = 3'd0;
    localparam logic [2:0] c_off_status = 3'd1;
    localparam logic [2:0] c_off_div_lo = 3'd2;
    localparam logic [2:0] c_off_div_hi = 3'd3;
    localparam logic [2:0] c_off_irq_en = 3'd4;
    localparam logic [2:0] c_off_level  = 3'd5;
    localparam int         c_nreg       = 6;

    localparam int c_st_tx_full  = 0;
    localparam int c_st_tx_empty = 1;
    localparam int c_st_rx_full  = 2;
    localparam int c_st_rx_empty = 3;
    localparam int c_st_tx_busy  = 4;
    localparam int c_st_ovr      = 5;
    localparam int c_st_fe       = 6;
    localparam int c_st_txdrop   = 7;

    localparam int c_min_div = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    function automatic logic [31:0] eff_div(input logic [31:0] d);
        return (d < 32'(c_min_div)) ? 32'(c_min_div) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo_io_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_io_if
// Description : CPU I/O bus request signals (select, address, strobes, data).
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_fifo_io_if;
    logic        CS;
    logic [13:0] adresse;
    logic        write;
    logic        read;
    logic [15:0] DATAout;

    modport master (output CS, output adresse, output write, output read, output DATAout);
    modport slave  (input  CS, input  adresse, input  write, input  read, input  DATAout);
endinterface
`default_nettype wire

// File: rtl/uart_fifo_io_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with occupancy count; push on full succeeds
//               only when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   i_push,
    input  wire logic                   i_pop,
    input  wire logic [WIDTH-1:0]       i_wdata,
    output wire logic [WIDTH-1:0]       o_rdata,
    output wire logic                   o_full,
    output wire logic                   o_empty,
    output wire logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             w_do_push, w_do_pop;

    assign o_empty   = (count_q == '0);
    assign o_full    = (count_q == (AW+1)'(DEPTH));
    assign o_count   = count_q;
    assign o_rdata   = mem_q[rd_ptr_q];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= i_wdata;
    end
endmodule
`default_nettype wire

// File: rtl/uart_fifo_io.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_io
// Description : Memory-mapped 8N1 UART with TX/RX FIFOs, programmable divisor,
//               sticky error flags and a registered level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_io
    import uart_fifo_pkg::*;
#(
    parameter logic [13:0] BASE    = 14'd16,
    parameter int          DEPTH   = 16,
    parameter int          DIV_W   = 24,
    parameter int          DIV_RST = 234
) (
    input  wire logic         clk,
    input  wire logic         rst,
    uart_fifo_io_if.slave     bus,
    output wire [15:0]        DATAin,
    input  wire logic         rx,
    output wire logic         tx,
    output wire logic         irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [13:0] w_off;
    logic        w_sel, w_wr, w_rd;
    logic [2:0]  w_reg;
    logic [15:0] w_rdata, w_status;
    logic [23:0] w_div24, w_div_wr;

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       irq_en_q, irq_en_d;
    logic             ovr_q, ovr_d, fe_q, fe_d, txdrop_q, txdrop_d, irq_q, irq_d;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [7:0]    tx_head, rx_head;
    logic          w_tx_push, w_tx_load, w_rx_pop, w_rx_push, w_set_ovr, w_set_fe;

    tx_state_t        tx_state_q, tx_state_d;
    logic             tx_q, tx_d;
    logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [2:0]       tx_bit_q, tx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d;
    logic             w_tx_tick;

    rx_state_t        rx_state_q, rx_state_d;
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_sh_q, rx_sh_d;
    logic             w_rx_tick, w_rx_half;

    assign w_off   = bus.adresse - BASE;
    assign w_sel   = bus.CS && (w_off < 14'(c_nreg));
    assign w_reg   = w_off[2:0];
    assign w_wr    = w_sel && bus.write;
    assign w_rd    = w_sel && bus.read;
    assign w_div24 = 24'(div_q);

    assign w_tx_push = w_wr && (w_reg == c_off_data);
    assign w_rx_pop  = w_rd && (w_reg == c_off_data);

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
        .clk, .rst,
        .i_push(w_tx_push), .i_pop(w_tx_load), .i_wdata(bus.DATAout[7:0]),
        .o_rdata(tx_head), .o_full(tx_full), .o_empty(tx_empty), .o_count(tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
        .clk, .rst,
        .i_push(w_rx_push), .i_pop(w_rx_pop), .i_wdata(rx_sh_q),
        .o_rdata(rx_head), .o_full(rx_full), .o_empty(rx_empty), .o_count(rx_count)
    );

    // Transmitter: the divisor is captured per frame, STOP chains straight into START.
    assign w_tx_tick = (tx_cnt_q == tx_div_q - DIV_W'(1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_d       = tx_q;
        tx_cnt_d   = (tx_state_q == TX_IDLE || w_tx_tick) ? '0 : tx_cnt_q + DIV_W'(1);
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        w_tx_load  = 1'b0;
        case (tx_state_q)
            TX_IDLE:  w_tx_load = !tx_empty;
            TX_START: if (w_tx_tick) begin
                tx_state_d = TX_DATA;
                tx_d       = tx_sh_q[0];
                tx_bit_d   = '0;
            end
            TX_DATA:  if (w_tx_tick) begin
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TX_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = tx_sh_q >> 1;
                    tx_d     = tx_sh_q[1];
                end
            end
            TX_STOP:  if (w_tx_tick) begin
                w_tx_load  = !tx_empty;
                tx_state_d = TX_IDLE;
            end
            default:  tx_state_d = TX_IDLE;
        endcase
        if (w_tx_load) begin
            tx_state_d = TX_START;
            tx_d       = 1'b0;
            tx_sh_d    = tx_head;
            tx_div_d   = DIV_W'(eff_div(32'(div_q)));
            tx_cnt_d   = '0;
        end
    end

    // Receiver: mid-bit sampling, half a bit after the falling edge and then every bit.
    assign w_rx_tick = (rx_cnt_q == rx_div_q - DIV_W'(1));
    assign w_rx_half = (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1));

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + DIV_W'(1);
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        w_rx_push  = 1'b0;
        w_set_ovr  = 1'b0;
        w_set_fe   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = DIV_W'(eff_div(32'(div_q)));
                end
            end
            RX_START: if (w_rx_half) begin
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
            end
            RX_DATA: if (w_rx_tick) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (w_rx_tick) begin
                rx_state_d = RX_IDLE;
                if (!rx_sync_q)                 w_set_fe  = 1'b1;
                else if (rx_full && !w_rx_pop)  w_set_ovr = 1'b1;
                else                            w_rx_push = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        div_d    = div_q;
        irq_en_d = irq_en_q;
        ovr_d    = ovr_q;
        fe_d     = fe_q;
        txdrop_d = txdrop_q;
        w_div_wr = w_div24;
        if (w_wr) begin
            case (w_reg)
                c_off_status: begin
                    if (bus.DATAout[c_st_ovr])    ovr_d    = 1'b0;
                    if (bus.DATAout[c_st_fe])     fe_d     = 1'b0;
                    if (bus.DATAout[c_st_txdrop]) txdrop_d = 1'b0;
                end
                c_off_div_lo: begin
                    w_div_wr[15:0] = bus.DATAout;
                    div_d          = DIV_W'(w_div_wr);
                end
                c_off_div_hi: begin
                    w_div_wr[23:16] = bus.DATAout[7:0];
                    div_d           = DIV_W'(w_div_wr);
                end
                c_off_irq_en: irq_en_d = bus.DATAout[2:0];
                default: ;
            endcase
        end
        if (w_set_ovr) ovr_d = 1'b1;
        if (w_set_fe)  fe_d  = 1'b1;
        if (w_tx_push && tx_full && !w_tx_load) txdrop_d = 1'b1;
        irq_d = |(irq_en_q & {ovr_q | fe_q | txdrop_q, tx_empty, ~rx_empty});
    end

    always_comb begin
        w_status = '0;
        w_status[c_st_tx_full]  = tx_full;
        w_status[c_st_tx_empty] = tx_empty;
        w_status[c_st_rx_full]  = rx_full;
        w_status[c_st_rx_empty] = rx_empty;
        w_status[c_st_tx_busy]  = (tx_state_q != TX_IDLE);
        w_status[c_st_ovr]      = ovr_q;
        w_status[c_st_fe]       = fe_q;
        w_status[c_st_txdrop]   = txdrop_q;
        w_rdata = '0;
        case (w_reg)
            c_off_data:   w_rdata = {rx_empty, 7'b0, rx_empty ? 8'h00 : rx_head};
            c_off_status: w_rdata = w_status;
            c_off_div_lo: w_rdata = w_div24[15:0];
            c_off_div_hi: w_rdata = {8'h00, w_div24[23:16]};
            c_off_irq_en: w_rdata = {13'b0, irq_en_q};
            c_off_level:  w_rdata = {8'(tx_count), 8'(rx_count)};
            default:      w_rdata = '0;
        endcase
    end

    assign DATAin = w_sel ? w_rdata : 16'bz;
    assign tx     = tx_q;
    assign irq    = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q      <= DIV_W'(DIV_RST);
            irq_en_q   <= '0;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            txdrop_q   <= 1'b0;
            irq_q      <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_cnt_q   <= '0;
            tx_div_q   <= DIV_W'(c_min_div);
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            rx_state_q <= RX_IDLE;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_cnt_q   <= '0;
            rx_div_q   <= DIV_W'(c_min_div);
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
        end else begin
            div_q      <= div_d;
            irq_en_q   <= irq_en_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            txdrop_q   <= txdrop_d;
            irq_q      <= irq_d;
            tx_state_q <= tx_state_d;
            tx_q       <= tx_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_state_q <= rx_state_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_cnt_q   <= rx_cnt_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_io
// Description : Directed bench for uart_fifo_io: register vectors plus serial
//               TX/RX, overflow, framing, glitch, interrupt and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_io;
    import uart_fifo_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    wire        tx, irq;
    wire [15:0] data_in;

    uart_fifo_io_if bus();

    uart_fifo_io #(.BASE(14'd16), .DEPTH(DEPTH), .DIV_W(24), .DIV_RST(234)) dut (
        .clk(clk), .rst(rst), .bus(bus), .DATAin(data_in),
        .rx(rx), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   c_n = 0;
    logic tx_log [1024];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) tx_log[cyc % 1024] <= tx;

    typedef struct {
        bit          wr;
        logic [2:0]  off;
        logic [15:0] wdata;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [15:0] d);
        bus.CS = 1'b1; bus.adresse = 14'd16 + 14'(off); bus.write = 1'b1; bus.DATAout = d;
        @(posedge clk);
        #1;
        bus.CS = 1'b0; bus.write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [15:0] v);
        bus.CS = 1'b1; bus.adresse = 14'd16 + 14'(off); bus.read = 1'b1;
        #1;
        v = data_in;
        @(posedge clk);
        #1;
        bus.CS = 1'b0; bus.read = 1'b0;
    endtask

    task automatic read_check(input logic [2:0] off, input logic [15:0] exp, input string name);
        logic [15:0] v;
        bus_read(off, v);
        check(name, 64'(v), 64'(exp));
    endtask

    // Serial frame at 4 cycles per bit.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        wait_cycles(4);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(4);
        end
        rx = stop;
        wait_cycles(4);
        rx = 1'b1;
        wait_cycles(4);
    endtask

    function automatic logic tx_at(input int k);
        return tx_log[(c_n + k) % 1024];
    endfunction

    function automatic void set_vec(input int i, input bit wr, input logic [2:0] off,
                                    input logic [15:0] wd, input logic [15:0] exp, input string name);
        vecs[i].wr = wr; vecs[i].off = off; vecs[i].wdata = wd; vecs[i].exp = exp; vecs[i].name = name;
    endfunction

    function automatic logic [7:0] ovf_byte(input int i);
        return 8'(i * 37 + 5);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [39:0] act40, exp40;
        logic [9:0]  act10;
        logic [7:0]  byt;
        int          bt;

        bus.CS = 1'b0; bus.adresse = '0; bus.write = 1'b0; bus.read = 1'b0; bus.DATAout = '0;

        set_vec(0,  0, c_off_div_lo, 16'h0000, 16'h00EA, "div_lo_rst");
        set_vec(1,  0, c_off_div_hi, 16'h0000, 16'h0000, "div_hi_rst");
        set_vec(2,  0, c_off_status, 16'h0000, 16'h000A, "status_rst");
        set_vec(3,  0, c_off_level,  16'h0000, 16'h0000, "level_rst");
        set_vec(4,  0, c_off_data,   16'h0000, 16'h8000, "data_empty");
        set_vec(5,  0, c_off_irq_en, 16'h0000, 16'h0000, "irq_en_rst");
        set_vec(6,  1, c_off_div_lo, 16'h1234, 16'h0000, "");
        set_vec(7,  0, c_off_div_lo, 16'h0000, 16'h1234, "div_lo_wr");
        set_vec(8,  1, c_off_div_hi, 16'hAB56, 16'h0000, "");
        set_vec(9,  0, c_off_div_hi, 16'h0000, 16'h0056, "div_hi_wr");
        set_vec(10, 1, c_off_irq_en, 16'hFFFF, 16'h0000, "");
        set_vec(11, 0, c_off_irq_en, 16'h0000, 16'h0007, "irq_en_wr");
        set_vec(12, 1, c_off_irq_en, 16'h0000, 16'h0000, "");
        set_vec(13, 1, c_off_div_hi, 16'h0000, 16'h0000, "");
        set_vec(14, 1, c_off_div_lo, 16'h0004, 16'h0000, "");
        set_vec(15, 0, c_off_div_lo, 16'h0000, 16'h0004, "div_lo_4");

        wait_cycles(3);
        rst = 1'b0;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_irq", 64'(irq), 64'd0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) bus_write(vecs[i].off, vecs[i].wdata);
            else            read_check(vecs[i].off, vecs[i].exp, vecs[i].name);
        end

        // Two back-to-back frames, checked cycle by cycle.
        bus_write(c_off_data, 16'h0055);
        c_n = cyc;
        bus_write(c_off_data, 16'h00A3);
        wait_cycles(82);
        check("tx_before_n1", 64'(tx_at(0)), 64'd1);
        for (int f = 0; f < 2; f++) begin
            byt = (f == 0) ? 8'h55 : 8'hA3;
            for (int j = 0; j < 40; j++) begin
                bt = j / 4;
                act40[j] = tx_at(1 + 40 * f + j);
                exp40[j] = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : byt[bt - 1];
            end
            check((f == 0) ? "tx_frame_55" : "tx_frame_a3", 64'(act40), 64'(exp40));
        end
        check("tx_idle_after", 64'(tx_at(81)), 64'd1);

        send_byte(8'h3C, 1'b1);
        read_check(c_off_status, 16'h0002, "rx_status_full1");
        read_check(c_off_level,  16'h0001, "rx_level1");
        read_check(c_off_data,   16'h003C, "rx_data_3c");
        read_check(c_off_data,   16'h8000, "rx_data_empty");
        read_check(c_off_status, 16'h000A, "rx_status_drained");

        send_byte(8'h81, 1'b0);
        read_check(c_off_status, 16'h004A, "fe_status");
        read_check(c_off_level,  16'h0000, "fe_level");
        bus_write(c_off_status, 16'h0040);
        read_check(c_off_status, 16'h000A, "fe_cleared");

        rx = 1'b0;
        wait_cycles(1);
        rx = 1'b1;
        wait_cycles(30);
        read_check(c_off_status, 16'h000A, "glitch_status");
        read_check(c_off_level,  16'h0000, "glitch_level");

        for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i), 1'b1);
        read_check(c_off_status, 16'h0026, "ovr_status");
        read_check(c_off_level,  16'h0010, "ovr_level");
        bus_write(c_off_status, 16'h0020);
        read_check(c_off_status, 16'h0006, "ovr_cleared");
        read_check(c_off_data,   16'h0010, "ovr_first_byte");

        // Reset in the middle of a TX frame with irq asserted.
        bus_write(c_off_irq_en, 16'h0001);
        bus_write(c_off_data, 16'h00F0);
        wait_cycles(6);
        check("pre_rst_tx", 64'(tx), 64'd0);
        check("pre_rst_irq", 64'(irq), 64'd1);
        rst = 1'b1;
        wait_cycles(1);
        check("mid_rst_tx", 64'(tx), 64'd1);
        check("mid_rst_irq", 64'(irq), 64'd0);
        rst = 1'b0;
        read_check(c_off_div_lo, 16'h00EA, "mid_rst_div");
        read_check(c_off_level,  16'h0000, "mid_rst_level");

        // TX overflow: one frame in flight, DEPTH+1 more writes.
        bus_write(c_off_div_lo, 16'h0004);
        bus_write(c_off_data, 16'(ovf_byte(0)));
        c_n = cyc;
        for (int i = 1; i <= DEPTH + 1; i++) bus_write(c_off_data, 16'(ovf_byte(i)));
        read_check(c_off_status, 16'h0099, "txdrop_status");
        read_check(c_off_level,  16'h1000, "txdrop_level");
        bus_write(c_off_irq_en, 16'h0002);
        wait_cycles(2);
        check("irq_fifo_nonempty", 64'(irq), 64'd0);
        for (int g = 0; g < 2000 && cyc != c_n + 641; g++) wait_cycles(1);
        check("irq_at_empty_edge", 64'(irq), 64'd0);
        wait_cycles(1);
        check("irq_after_empty", 64'(irq), 64'd1);
        for (int g = 0; g < 2000 && cyc < c_n + 690; g++) wait_cycles(1);
        for (int f = 0; f <= DEPTH; f++) begin
            for (int b = 0; b < 10; b++) act10[b] = tx_at(1 + 40 * f + 4 * b + 2);
            check($sformatf("txdrop_frame%0d", f), 64'(act10), 64'({1'b1, ovf_byte(f), 1'b0}));
        end
        check("txdrop_idle_after", 64'(tx_at(681)), 64'd1);
        read_check(c_off_status, 16'h008A, "txdrop_done_status");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
